// File: rtl/bsg_link_to_manycore_link_serdes_pkg.sv
// Shared constants and width helpers for the manycore <-> bsg_link serdes bridge.
// Net indices select the fwd/rev entry of the two-element bsg_link arrays.
package bsg_link_to_manycore_link_serdes_pkg;

   localparam int FWD_IDX = 1;
   localparam int REV_IDX = 0;

   // Manycore opcode / response-type field width
   localparam int MC_OP_W = 2;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_e;

   function automatic int flits_for_width(input int pkt_w, input int link_w);
      return (pkt_w + link_w - 1) / link_w;
   endfunction

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int fwd_pkt_width(input int addr_w, input int data_w,
                                        input int x_w, input int y_w);
      return addr_w + MC_OP_W + data_w + 2 * (x_w + y_w);
   endfunction

   function automatic int rev_pkt_width(input int data_w, input int x_w, input int y_w);
      return MC_OP_W + data_w + x_w + y_w;
   endfunction

   // Each link carries {v, packet, ready_and_rev}
   function automatic int link_sif_width(input int addr_w, input int data_w,
                                         input int x_w, input int y_w);
      return fwd_pkt_width(addr_w, data_w, x_w, y_w) + rev_pkt_width(data_w, x_w, y_w) + 4;
   endfunction

   function automatic int ral_width(input int link_w);
      return link_w + 2;
   endfunction

endpackage

// File: rtl/bsg_link_to_manycore_link_serdes_packet_serdes.sv
// One bsg_link net: PISO (packet -> LSB-first flits) and SIPO (flits -> packet).
// Both halves are independent ready/valid pipelines sharing only clock and reset.
module bsg_link_packet_serdes
   import bsg_link_to_manycore_link_serdes_pkg::*;
#(
   parameter int pkt_width_p  = 8,
   parameter int link_width_p = 8
)(
   input  logic                    i_clk,
   input  logic                    i_reset,
   // TX: packet in, flits out
   input  logic                    i_tx_pkt_v,
   input  logic [pkt_width_p-1:0]  i_tx_pkt,
   output logic                    o_tx_pkt_ready,
   output logic                    o_tx_flit_v,
   output logic [link_width_p-1:0] o_tx_flit,
   input  logic                    i_tx_flit_ready,
   // RX: flits in, packet out
   input  logic                    i_rx_flit_v,
   input  logic [link_width_p-1:0] i_rx_flit,
   output logic                    o_rx_flit_ready,
   output logic                    o_rx_pkt_v,
   output logic [pkt_width_p-1:0]  o_rx_pkt,
   input  logic                    i_rx_pkt_ready
);

   localparam int            N    = flits_for_width(pkt_width_p, link_width_p);
   localparam int            CW   = safe_clog2(N);
   localparam int            FW   = N * link_width_p;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // ---------------- TX (PISO) ----------------
   tx_state_e                         r_tx_state, w_tx_state_nxt;
   logic [CW-1:0]                     r_tx_count;
   logic [N-1:0][link_width_p-1:0]    r_tx_flits;
   logic                              w_tx_last, w_tx_flit_acc, w_tx_pkt_acc;

   assign w_tx_last     = (r_tx_count == LAST);
   assign w_tx_flit_acc = (r_tx_state == TX_SEND) & i_tx_flit_ready;
   assign w_tx_pkt_acc  = i_tx_pkt_v & o_tx_pkt_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_tx_state <= TX_IDLE;
      else         r_tx_state <= w_tx_state_nxt;
   end

   // Ready reopens on the last flit accept so back-to-back packets leave no bubble
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      o_tx_pkt_ready = 1'b0;
      o_tx_flit_v    = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            o_tx_pkt_ready = ~i_reset;
            if (i_tx_pkt_v & ~i_reset) w_tx_state_nxt = TX_SEND;
         end
         TX_SEND: begin
            o_tx_flit_v = 1'b1;
            if (w_tx_flit_acc & w_tx_last) begin
               o_tx_pkt_ready = ~i_reset;
               if (~(i_tx_pkt_v & ~i_reset)) w_tx_state_nxt = TX_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)            r_tx_count <= '0;
      else if (w_tx_pkt_acc)  r_tx_count <= '0;
      else if (w_tx_flit_acc) r_tx_count <= w_tx_last ? '0 : r_tx_count + 1'b1;
   end

   // Zero-extension here is what clears the padding bits of the last flit
   always_ff @(posedge i_clk) begin
      if (w_tx_pkt_acc) r_tx_flits <= FW'(i_tx_pkt);
   end

   always_comb begin
      o_tx_flit = r_tx_flits[0];
      for (int k = 1; k < N; k++)
         if (r_tx_count == CW'(k)) o_tx_flit = r_tx_flits[k];
   end

   // ---------------- RX (SIPO) ----------------
   logic                              r_rx_full;
   logic [CW-1:0]                     r_rx_count;
   logic [N-1:0][link_width_p-1:0]    r_rx_flits;
   logic [FW-1:0]                     w_rx_flat;
   logic                              w_rx_last, w_rx_flit_acc, w_rx_pkt_acc;

   assign w_rx_pkt_acc    = r_rx_full & i_rx_pkt_ready;
   assign o_rx_flit_ready = ~i_reset & (~r_rx_full | w_rx_pkt_acc);
   assign w_rx_flit_acc   = i_rx_flit_v & o_rx_flit_ready;
   assign w_rx_last       = (r_rx_count == LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_full  <= 1'b0;
         r_rx_count <= '0;
      end else begin
         if (w_rx_flit_acc) r_rx_count <= w_rx_last ? '0 : r_rx_count + 1'b1;
         // A completing packet wins over a same-cycle drain of the previous one
         if (w_rx_flit_acc & w_rx_last) r_rx_full <= 1'b1;
         else if (w_rx_pkt_acc)         r_rx_full <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < N; k++)
         if (w_rx_flit_acc && (r_rx_count == CW'(k))) r_rx_flits[k] <= i_rx_flit;
   end

   assign w_rx_flat  = r_rx_flits;
   assign o_rx_pkt   = w_rx_flat[pkt_width_p-1:0];
   assign o_rx_pkt_v = r_rx_full;

endmodule

// File: rtl/bsg_link_to_manycore_link_serdes.sv
// Far-end manycore-over-bsg_link endpoint: one packet serdes per net (fwd, rev).
// This level only unpacks/packs the link structs; all sequencing lives in the serdes.
module bsg_link_to_manycore_link_serdes
   import bsg_link_to_manycore_link_serdes_pkg::*;
#(
   parameter int addr_width_p     = 28,
   parameter int data_width_p     = 32,
   parameter int x_cord_width_p   = 7,
   parameter int y_cord_width_p   = 7,
   parameter int bsg_link_width_p = 16
)(
   input  logic clk_i,
   input  logic reset_i,
   input  logic [link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)-1:0] links_sif_i,
   output logic [link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)-1:0] links_sif_o,
   input  logic [1:0][ral_width(bsg_link_width_p)-1:0] bsg_link_i,
   output logic [1:0][ral_width(bsg_link_width_p)-1:0] bsg_link_o
);

   localparam int FWD_W = fwd_pkt_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
   localparam int REV_W = rev_pkt_width(data_width_p, x_cord_width_p, y_cord_width_p);

   typedef struct packed {
      logic [addr_width_p-1:0]   addr;
      logic [MC_OP_W-1:0]        op;
      logic [data_width_p-1:0]   payload;
      logic [y_cord_width_p-1:0] src_y_cord;
      logic [x_cord_width_p-1:0] src_x_cord;
      logic [y_cord_width_p-1:0] y_cord;
      logic [x_cord_width_p-1:0] x_cord;
   } fwd_pkt_s;

   typedef struct packed {
      logic [MC_OP_W-1:0]        pkt_type;
      logic [data_width_p-1:0]   data;
      logic [y_cord_width_p-1:0] y_cord;
      logic [x_cord_width_p-1:0] x_cord;
   } rev_pkt_s;

   typedef struct packed {
      logic     v;
      fwd_pkt_s data;
      logic     ready_and_rev;
   } fwd_link_s;

   typedef struct packed {
      logic     v;
      rev_pkt_s data;
      logic     ready_and_rev;
   } rev_link_s;

   typedef struct packed {
      fwd_link_s fwd;
      rev_link_s rev;
   } link_sif_s;

   typedef struct packed {
      logic                        v;
      logic [bsg_link_width_p-1:0] data;
      logic                        ready_and_rev;
   } ral_s;

   link_sif_s w_sif_in, w_sif_out;
   ral_s      w_fwd_in, w_rev_in, w_fwd_out, w_rev_out;

   assign w_sif_in = links_sif_i;
   assign w_fwd_in = bsg_link_i[FWD_IDX];
   assign w_rev_in = bsg_link_i[REV_IDX];

   logic                        w_fwd_tx_pkt_ready, w_fwd_tx_flit_v, w_fwd_rx_flit_ready, w_fwd_rx_pkt_v;
   logic [bsg_link_width_p-1:0] w_fwd_tx_flit;
   logic [FWD_W-1:0]            w_fwd_rx_pkt;
   logic                        w_rev_tx_pkt_ready, w_rev_tx_flit_v, w_rev_rx_flit_ready, w_rev_rx_pkt_v;
   logic [bsg_link_width_p-1:0] w_rev_tx_flit;
   logic [REV_W-1:0]            w_rev_rx_pkt;

   bsg_link_packet_serdes #(.pkt_width_p(FWD_W), .link_width_p(bsg_link_width_p)) u_fwd (
      .i_clk           (clk_i),
      .i_reset         (reset_i),
      .i_tx_pkt_v      (w_sif_in.fwd.v),
      .i_tx_pkt        (w_sif_in.fwd.data),
      .o_tx_pkt_ready  (w_fwd_tx_pkt_ready),
      .o_tx_flit_v     (w_fwd_tx_flit_v),
      .o_tx_flit       (w_fwd_tx_flit),
      .i_tx_flit_ready (w_fwd_in.ready_and_rev),
      .i_rx_flit_v     (w_fwd_in.v),
      .i_rx_flit       (w_fwd_in.data),
      .o_rx_flit_ready (w_fwd_rx_flit_ready),
      .o_rx_pkt_v      (w_fwd_rx_pkt_v),
      .o_rx_pkt        (w_fwd_rx_pkt),
      .i_rx_pkt_ready  (w_sif_in.fwd.ready_and_rev)
   );

   bsg_link_packet_serdes #(.pkt_width_p(REV_W), .link_width_p(bsg_link_width_p)) u_rev (
      .i_clk           (clk_i),
      .i_reset         (reset_i),
      .i_tx_pkt_v      (w_sif_in.rev.v),
      .i_tx_pkt        (w_sif_in.rev.data),
      .o_tx_pkt_ready  (w_rev_tx_pkt_ready),
      .o_tx_flit_v     (w_rev_tx_flit_v),
      .o_tx_flit       (w_rev_tx_flit),
      .i_tx_flit_ready (w_rev_in.ready_and_rev),
      .i_rx_flit_v     (w_rev_in.v),
      .i_rx_flit       (w_rev_in.data),
      .o_rx_flit_ready (w_rev_rx_flit_ready),
      .o_rx_pkt_v      (w_rev_rx_pkt_v),
      .o_rx_pkt        (w_rev_rx_pkt),
      .i_rx_pkt_ready  (w_sif_in.rev.ready_and_rev)
   );

   // fwd ready_and_rev out is a credit pulse: one per request actually taken
   always_comb begin
      w_sif_out                   = '0;
      w_sif_out.fwd.v             = w_fwd_rx_pkt_v;
      w_sif_out.fwd.data          = fwd_pkt_s'(w_fwd_rx_pkt);
      w_sif_out.fwd.ready_and_rev = w_sif_in.fwd.v & w_fwd_tx_pkt_ready;
      w_sif_out.rev.v             = w_rev_rx_pkt_v;
      w_sif_out.rev.data          = rev_pkt_s'(w_rev_rx_pkt);
      w_sif_out.rev.ready_and_rev = w_rev_tx_pkt_ready;
      w_fwd_out                   = '{v: w_fwd_tx_flit_v, data: w_fwd_tx_flit, ready_and_rev: w_fwd_rx_flit_ready};
      w_rev_out                   = '{v: w_rev_tx_flit_v, data: w_rev_tx_flit, ready_and_rev: w_rev_rx_flit_ready};
   end

   assign links_sif_o         = w_sif_out;
   assign bsg_link_o[FWD_IDX] = w_fwd_out;
   assign bsg_link_o[REV_IDX] = w_rev_out;

endmodule
